// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU arbiter slice.
//   - ALU_Ctl operation codes
//   - arbiter FSM state encoding
//   - is_legal_ctl(): true for the six supported operation codes
package alu_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_ctl(input logic [3:0] ctl);
    case (ctl)
      CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: is_legal_ctl = 1'b1;
      default:                                             is_legal_ctl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ALU.sv
// ALU
// Purely combinational 32-bit ALU shared by both requesters of alu_arbiter.
// Ports:
//   A, B       in  32  operands
//   ALU_Ctl    in  4   operation code (see alu_pkg)
//   ALU_Out    out 32  result, 0 for an illegal code
//   Zero_Flag  out 1   result is zero (always 0 for an illegal code)
//   Error      out 1   ALU_Ctl is not a supported code
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALU_Ctl,
  output logic [31:0] ALU_Out,
  output logic        Zero_Flag,
  output logic        Error
);

  always_comb begin
    ALU_Out = '0;
    Error   = !is_legal_ctl(ALU_Ctl);
    case (ALU_Ctl)
      CTL_AND: ALU_Out = A & B;
      CTL_OR:  ALU_Out = A | B;
      CTL_ADD: ALU_Out = A + B;
      CTL_SUB: ALU_Out = A - B;
      CTL_SLT: ALU_Out = {31'b0, ($signed(A) < $signed(B))};
      CTL_NOR: ALU_Out = ~(A | B);
      default: ALU_Out = '0;
    endcase
    // An illegal code reports a zero result but must not claim Zero_Flag.
    Zero_Flag = !Error && (ALU_Out == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two requesters share one ALU. A request is accepted in IDLE, computed in
// EXEC and presented in RESP until the consumer takes it.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/A/B/Ctl         requester N operation (N = 0, 1)
//   reqN_ready                 out: requester N accepted this cycle
//   rsp_valid/id/Output/
//   rsp_Zero_Flag/rsp_Error    out: registered response
//   rsp_ready                  in:  consumer takes the response
//   op_count                   out: completed responses, wraps at 2^CNT_W
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_A,
  input  logic [31:0]      req0_B,
  input  logic [3:0]       req0_Ctl,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_A,
  input  logic [31:0]      req1_B,
  input  logic [3:0]       req1_Ctl,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [31:0]      rsp_Output,
  output logic             rsp_Zero_Flag,
  output logic             rsp_Error,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] op_count
);

  state_t      state;
  logic        last_grant;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic [3:0]  lat_ctl;
  logic        lat_id;

  logic        any_valid;
  logic        grant_id;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_err;

  // On a tie the requester that did not win last time goes next; otherwise
  // the single valid requester wins (grant_id is don't-care with none valid).
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  // The ready pulse has to coincide with the accepting IDLE cycle, so it is
  // decoded from the state register rather than registered itself.
  assign req0_ready = !reset && (state == ST_IDLE) && any_valid && !grant_id;
  assign req1_ready = !reset && (state == ST_IDLE) && any_valid &&  grant_id;

  ALU u_alu (
    .A         (lat_a),
    .B         (lat_b),
    .ALU_Ctl   (lat_ctl),
    .ALU_Out   (alu_out),
    .Zero_Flag (alu_zero),
    .Error     (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      lat_a         <= '0;
      lat_b         <= '0;
      lat_ctl       <= '0;
      lat_id        <= 1'b0;
      op_count      <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_Output    <= '0;
      rsp_Zero_Flag <= 1'b0;
      rsp_Error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            lat_a      <= grant_id ? req1_A   : req0_A;
            lat_b      <= grant_id ? req1_B   : req0_B;
            lat_ctl    <= grant_id ? req1_Ctl : req0_Ctl;
            lat_id     <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_Output    <= alu_out;
          rsp_Zero_Flag <= alu_zero;
          rsp_Error     <= alu_err;
          rsp_id        <= lat_id;
          rsp_valid     <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= CNT_W'(op_count + 1'b1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter (built with CNT_W=2 so the counter wrap
// is reachable). Expected results come from an arithmetic reference of the
// operation table plus a round-robin winner rule kept in bench variables.
module tb_alu_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_A, req0_B, req1_A, req1_B;
  logic [3:0]       req0_Ctl, req1_Ctl;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_id, rsp_Zero_Flag, rsp_Error, rsp_ready;
  logic [31:0]      rsp_Output;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  // Reference state: pending operations per requester, last winner, completions.
  bit          pend0, pend1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  c0, c1;
  logic        last_w;
  int          done_cnt;

  logic [31:0] obs_out;
  logic        obs_zero, obs_err, obs_id;

  logic [3:0]  code_tab [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b1111, 4'b0011};
  int          wrap_seq [5] = '{1, 2, 3, 0, 1};

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_A        (req0_A),
    .req0_B        (req0_B),
    .req0_Ctl      (req0_Ctl),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_A        (req1_A),
    .req1_B        (req1_B),
    .req1_Ctl      (req1_Ctl),
    .req1_ready    (req1_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_Output    (rsp_Output),
    .rsp_Zero_Flag (rsp_Zero_Flag),
    .rsp_Error     (rsp_Error),
    .rsp_ready     (rsp_ready),
    .op_count      (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns {error, zero, result}.
  function automatic logic [33:0] ref_alu(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        err;
    err = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: begin r = 32'd0; err = 1'b1; end
    endcase
    return {err, (!err && r == 32'd0), r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Queue a new operation on requester id; it stays valid until granted.
  task automatic applyStimulus(input int id, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] c);
    if (id == 0) begin pend0 = 1; a0 = a; b0 = b; c0 = c; end
    else         begin pend1 = 1; a1 = a; b1 = b; c1 = c; end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    pend0 = 0; pend1 = 0;
    @(posedge clk); #1;
    checkOutput("ready0 in reset", 32'(req0_ready), 0);
    checkOutput("ready1 in reset", 32'(req1_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_w = 1'b1;
    done_cnt = 0;
    checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset rsp_id", 32'(rsp_id), 0);
    checkOutput("reset rsp_Output", rsp_Output, 0);
    checkOutput("reset rsp_Zero", 32'(rsp_Zero_Flag), 0);
    checkOutput("reset rsp_Error", 32'(rsp_Error), 0);
    checkOutput("reset op_count", 32'(op_count), 0);
  endtask

  // One full transaction starting in an IDLE cycle; hold = cycles with
  // rsp_ready low once the response is up.
  task automatic serve(input int hold);
    logic        w;
    logic [33:0] exp;
    logic [31:0] oa, ob;
    logic [3:0]  oc;
    req0_valid = pend0; req0_A = a0; req0_B = b0; req0_Ctl = c0;
    req1_valid = pend1; req1_A = a1; req1_B = b1; req1_Ctl = c1;
    rsp_ready = 1'b1;
    #1;
    w = (pend0 && pend1) ? ~last_w : pend1;
    checkOutput("grant ready0", 32'(req0_ready), 32'(!w));
    checkOutput("grant ready1", 32'(req1_ready), 32'(w));
    last_w = w;
    oa = w ? a1 : a0; ob = w ? b1 : b0; oc = w ? c1 : c0;
    exp = ref_alu(oc, oa, ob);

    @(posedge clk); #1;
    // Winner withdraws; scramble its operands to prove they were latched.
    if (w) begin pend1 = 0; req1_valid = 0; req1_A = $urandom; req1_B = $urandom; end
    else   begin pend0 = 0; req0_valid = 0; req0_A = $urandom; req0_B = $urandom; end
    #1;
    checkOutput("exec ready0", 32'(req0_ready), 0);
    checkOutput("exec ready1", 32'(req1_ready), 0);
    checkOutput("exec rsp_valid", 32'(rsp_valid), 0);

    @(posedge clk); #1;
    if (hold > 0) rsp_ready = 1'b0;
    #1;
    checkOutput("rsp_valid", 32'(rsp_valid), 1);
    checkOutput("rsp_id", 32'(rsp_id), 32'(w));
    checkOutput("rsp_Output", rsp_Output, exp[31:0]);
    checkOutput("rsp_Zero_Flag", 32'(rsp_Zero_Flag), 32'(exp[32]));
    checkOutput("rsp_Error", 32'(rsp_Error), 32'(exp[33]));
    checkOutput("op_count before", 32'(op_count), 32'(done_cnt % (1 << CNT_W)));
    obs_out = rsp_Output; obs_zero = rsp_Zero_Flag; obs_err = rsp_Error; obs_id = rsp_id;

    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == hold) rsp_ready = 1'b1;
      #1;
      checkOutput("held rsp_valid", 32'(rsp_valid), 1);
      checkOutput("held rsp_Output", rsp_Output, exp[31:0]);
      checkOutput("held rsp_Error", 32'(rsp_Error), 32'(exp[33]));
      checkOutput("held no grant", 32'({req1_ready, req0_ready}), 0);
    end

    @(posedge clk); #1;
    done_cnt++;
    checkOutput("rsp drop", 32'(rsp_valid), 0);
    checkOutput("op_count after", 32'(op_count), 32'(done_cnt % (1 << CNT_W)));
  endtask

  initial begin
    a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
    req0_A = 0; req0_B = 0; req0_Ctl = 0; req1_A = 0; req1_B = 0; req1_Ctl = 0;
    resetDut();

    // Sole requester, AND.
    applyStimulus(0, 32'h10696671, 32'h12345678, 4'b0000);
    serve(0);
    checkOutput("AND id", 32'(obs_id), 0);
    checkOutput("AND out", obs_out, 32'h10204670);
    checkOutput("AND err", 32'(obs_err), 0);

    // Tie from reset: req0 first, then req1.
    resetDut();
    applyStimulus(0, 32'h10696671, 32'h12345678, 4'b0010);
    applyStimulus(1, 32'h10696671, 32'h12345678, 4'b0110);
    serve(0);
    checkOutput("RR1 id", 32'(obs_id), 0);
    checkOutput("ADD out", obs_out, 32'h229DBCE9);
    serve(0);
    checkOutput("RR2 id", 32'(obs_id), 1);
    checkOutput("SUB out", obs_out, 32'hFE350FF9);

    // SLT and zero flag.
    applyStimulus(0, 32'h10696671, 32'h12345678, 4'b0111);
    serve(0);
    checkOutput("SLT out", obs_out, 32'h1);
    checkOutput("SLT zero", 32'(obs_zero), 0);
    applyStimulus(1, 32'h10696671, 32'h10696671, 4'b0110);
    serve(0);
    checkOutput("SUBZ out", obs_out, 0);
    checkOutput("SUBZ zero", 32'(obs_zero), 1);

    // Illegal code under backpressure while the other requester waits.
    applyStimulus(1, 32'hDEADBEEF, 32'h0BADF00D, 4'b1111);
    serve(0);
    applyStimulus(0, 32'hFFFFFFFF, 32'h00000001, 4'b1111);
    applyStimulus(1, 32'h00000005, 32'h00000003, 4'b0001);
    serve(5);
    checkOutput("ILL err", 32'(obs_err), 1);
    checkOutput("ILL out", obs_out, 0);
    checkOutput("ILL zero", 32'(obs_zero), 0);
    serve(0);
    checkOutput("after ILL out", obs_out, 32'h7);

    // Reset during EXEC discards the operation.
    applyStimulus(0, 32'h11111111, 32'h22222222, 4'b0010);
    req0_valid = 1; req0_A = a0; req0_B = b0; req0_Ctl = c0;
    #1;
    checkOutput("mid grant", 32'(req0_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 0; pend0 = 0;
    #1;
    checkOutput("mid ready in reset", 32'({req1_ready, req0_ready}), 0);
    @(posedge clk); #1;
    reset = 1'b0; last_w = 1'b1; done_cnt = 0;
    checkOutput("mid rsp_valid", 32'(rsp_valid), 0);
    checkOutput("mid op_count", 32'(op_count), 0);
    checkOutput("mid rsp_Output", rsp_Output, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("discarded no rsp", 32'(rsp_valid), 0);
    end
    applyStimulus(0, 32'h3, 32'h4, 4'b0010);
    applyStimulus(1, 32'h3, 32'h4, 4'b0110);
    serve(0);
    checkOutput("post-reset tie id", 32'(obs_id), 0);
    serve(0);

    // Counter wrap with CNT_W=2.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i % 2, $urandom, $urandom, code_tab[$urandom_range(0, 5)]);
      serve(0);
      checkOutput("wrap seq", 32'(op_count), 32'(wrap_seq[i]));
    end

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if (!pend0 && $urandom_range(0, 1) == 1)
        applyStimulus(0, ra, rb, code_tab[$urandom_range(0, 7)]);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if (!pend1 && ($urandom_range(0, 1) == 1 || !pend0))
        applyStimulus(1, ra, rb, code_tab[$urandom_range(0, 7)]);
      serve($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
